// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the F-stage fetch sequencer: FSM encodings, reset/exception
// vectors, instruction-memory window and the redirect bundle type.
package fetch_ctrl_pkg;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DEF = 4096;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  // Kill-and-redirect request from CP0 (exception entry or eret).
  typedef struct packed {
    logic        kill;
    logic [31:0] target;
  } redirect_t;

  // Highest word address that still lies inside the instruction memory.
  function automatic logic [31:0] im_last(input logic [31:0] base, input int unsigned words);
    return base + 32'(words * 4) - 32'd4;
  endfunction

endpackage

// File: rtl/fetch_ctrl_addr_chk.sv
// Pure combinational fetch-address check: flags misaligned PCs and PCs outside the
// instruction-memory window so the sequencer can raise AdEL without touching memory.
module fetch_ctrl_addr_chk
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
  input  logic [31:0] addr_i,
  output logic        bad_o
);

  localparam logic [31:0] IM_LAST = im_last(IM_BASE, IM_WORDS);

  logic misaligned;
  logic out_of_range;

  assign misaligned   = (addr_i[1:0] != 2'b00);
  assign out_of_range = (addr_i < IM_BASE) || (addr_i > IM_LAST);
  assign bad_o        = misaligned || out_of_range;

endmodule

// File: rtl/fetch_ctrl.sv
// F-stage sequencer: owns the PC, runs the instruction-memory request handshake and
// applies sequential, delayed-branch, exception and eret redirects.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_PC   = EXC_PC_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        except_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic        im_req,
  input  logic        im_ready,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic [4:0]  fetch_exc
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_target_q, br_target_d;

  logic        addr_bad;
  logic        fetch_done;
  redirect_t   redir;

  fetch_ctrl_addr_chk #(
    .IM_BASE  (IM_BASE),
    .IM_WORDS (IM_WORDS)
  ) u_addr_chk (
    .addr_i (pc_q),
    .bad_o  (addr_bad)
  );

  // Exception entry outranks eret when both arrive together.
  assign redir.kill   = except_req || eret_req;
  assign redir.target = except_req ? EXC_PC : epc;

  // A bad address completes instantly with AdEL; a good one waits for memory.
  assign fetch_done = addr_bad || im_ready;

  assign pc = pc_q;

  // NOTE: every signal assigned here gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    br_pend_d   = br_pend_q;
    br_target_d = br_target_q;
    im_req      = 1'b0;
    fetch_valid = 1'b0;
    fetch_exc   = EXC_NONE;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        im_req = !addr_bad;
        if (redir.kill) begin
          br_pend_d = 1'b0;
          if (fetch_done) begin
            pc_d = redir.target;
          end else begin
            pend_d  = redir.target;
            state_d = ST_DRAIN;
          end
        end else if (fetch_done) begin
          fetch_valid = 1'b1;
          fetch_exc   = addr_bad ? EXC_ADEL : EXC_NONE;
          if (en) begin
            if (br_pend_q)         pc_d = br_target_q;
            else if (branch_valid) pc_d = branch_target;
            else                   pc_d = pc_q + 32'd4;
            br_pend_d = 1'b0;
          end else if (branch_valid) begin
            br_pend_d   = 1'b1;
            br_target_d = branch_target;
          end
        end else if (branch_valid) begin
          // Delay slot still in flight: remember where to go once it is consumed.
          br_pend_d   = 1'b1;
          br_target_d = branch_target;
        end
      end

      ST_DRAIN: begin
        // The killed request must complete before the address may change.
        im_req = 1'b1;
        if (redir.kill) begin
          pend_d = redir.target;
        end
        if (im_ready) begin
          pc_d    = redir.kill ? redir.target : pend_q;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      pend_q      <= 32'd0;
      br_pend_q   <= 1'b0;
      br_target_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      br_pend_q   <= br_pend_d;
      br_target_q <= br_target_d;
    end
  end

endmodule
